// File: rtl/truth_table_sweeper_pkg.sv
// Purpose : shared types for the truth-table sweeper.
//           State encoding: IDLE=0, APPLY=1, SAMPLE=2, DONE=3, width ST_W=2.
// Ports   : none (package).
package truth_table_sweeper_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/sweep_cmp.sv
// Purpose : combinational compare of one sampled function output against the
//           expected truth-table bit for the current vector.
// Ports   : i_y          sampled function output
//           i_idx        current vector index
//           i_none_yet   no mismatch recorded so far in this sweep
//           o_mismatch   i_y differs from EXPECT[i_idx]
//           o_first_fail mismatch and it is the first one of the sweep
module sweep_cmp #(
    parameter int                  N_IN   = 3,
    parameter logic [(2**N_IN)-1:0] EXPECT = 'h3F
) (
    input  logic            i_y,
    input  logic [N_IN-1:0] i_idx,
    input  logic            i_none_yet,
    output logic            o_mismatch,
    output logic            o_first_fail
);

    assign o_mismatch   = (i_y != EXPECT[i_idx]);
    assign o_first_fail = o_mismatch & i_none_yet;

endmodule

// File: rtl/truth_table_sweeper.sv
// Purpose : drives every input combination 0..2^N_IN-1 onto an external
//           combinational function, holds each for SETTLE cycles, samples the
//           output into a truth table and compares it with EXPECT.
// Ports   : clk        clock, rising edge
//           rst_n      synchronous active-low reset
//           start      begin sweep (IDLE only)
//           abort      cancel sweep in APPLY/SAMPLE
//           dut_vec    registered vector to the function (MSB = a)
//           dut_y      function output, sampled in SAMPLE
//           busy       high in APPLY/SAMPLE
//           done       one-cycle pulse at completion
//           pass       table matched EXPECT (valid from done until next start)
//           table_out  captured truth table
//           fail_idx   lowest mismatching index
//           fail_cnt   number of mismatching vectors
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int                   N_IN   = 3,
    parameter int                   SETTLE = 1,
    parameter logic [(2**N_IN)-1:0] EXPECT = 'h3F
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic [N_IN-1:0]        dut_vec,
    input  logic                   dut_y,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(2**N_IN)-1:0]   table_out,
    output logic [N_IN-1:0]        fail_idx,
    output logic [N_IN:0]          fail_cnt
);

    localparam int NV = 2**N_IN;
    localparam int CW = N_IN + 1;
    // settle counter runs 0..SETTLE-1, so it needs clog2(SETTLE) bits (min 1)
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST_IDX   = CW'(NV - 1);
    localparam logic [SW-1:0] LAST_SETTL = SW'(SETTLE - 1);

    state_e              r_state, w_next;
    logic [CW-1:0]       r_idx;
    logic [SW-1:0]       r_settle;
    logic [N_IN-1:0]     r_vec;
    logic                r_pass;
    logic [NV-1:0]       r_table;
    logic [N_IN-1:0]     r_fail_idx;
    logic [CW-1:0]       r_fail_cnt;

    logic                w_run;
    logic                w_go;
    logic                w_settled;
    logic                w_last;
    logic                w_none_yet;
    logic                w_mismatch;
    logic                w_first_fail;

    assign w_run      = (r_state == ST_APPLY) || (r_state == ST_SAMPLE);
    assign w_go       = start && !abort;
    assign w_settled  = (r_settle == LAST_SETTL);
    assign w_last     = (r_idx == LAST_IDX);
    assign w_none_yet = (r_fail_cnt == '0);

    sweep_cmp #(
        .N_IN   (N_IN),
        .EXPECT (EXPECT)
    ) u_cmp (
        .i_y          (dut_y),
        .i_idx        (r_idx[N_IN-1:0]),
        .i_none_yet   (w_none_yet),
        .o_mismatch   (w_mismatch),
        .o_first_fail (w_first_fail)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_go) w_next = ST_APPLY;
            ST_APPLY:  begin
                if (abort)          w_next = ST_IDLE;
                else if (w_settled) w_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)       w_next = ST_IDLE;
                else if (w_last) w_next = ST_DONE;
                else             w_next = ST_APPLY;
            end
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_settle   <= '0;
            r_vec      <= '0;
            r_pass     <= 1'b0;
            r_table    <= '0;
            r_fail_idx <= '0;
            r_fail_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_idx      <= '0;
                        r_settle   <= '0;
                        r_vec      <= '0;
                        r_pass     <= 1'b0;
                        r_table    <= '0;
                        r_fail_idx <= '0;
                        r_fail_cnt <= '0;
                    end
                end
                ST_APPLY: begin
                    if (abort) begin
                        r_vec    <= '0;
                        r_pass   <= 1'b0;
                        r_settle <= '0;
                    end else if (w_settled) begin
                        r_settle <= '0;
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        r_vec  <= '0;
                        r_pass <= 1'b0;
                    end else begin
                        r_table[r_idx[N_IN-1:0]] <= dut_y;
                        if (w_mismatch)   r_fail_cnt <= r_fail_cnt + CW'(1);
                        if (w_first_fail) r_fail_idx <= r_idx[N_IN-1:0];
                        if (w_last) begin
                            // include this final sample so pass is valid in DONE
                            r_pass <= w_none_yet && !w_mismatch;
                        end else begin
                            r_idx <= r_idx + CW'(1);
                            r_vec <= r_idx[N_IN-1:0] + N_IN'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dut_vec   = r_vec;
    assign busy      = w_run;
    assign done      = (r_state == ST_DONE);
    assign pass      = r_pass;
    assign table_out = r_table;
    assign fail_idx  = r_fail_idx;
    assign fail_cnt  = r_fail_cnt;

endmodule
